// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types, defaults and helpers for the PLL lock supervisor
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLLRST,
        WAIT_LOCK,
        FILTER,
        HOLD,
        RUN
    } pll_state_e;

    localparam int DEF_LOCK_FILTER   = 1024;
    localparam int DEF_RST_HOLD      = 256;
    localparam int DEF_LOCK_TIMEOUT  = 1048576;
    localparam int DEF_PLLRST_CYCLES = 16;
    localparam int DEF_CNT_W         = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// rtl/pll_lock_supervisor_sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - sequences PLL reset, lock filtering and system reset release
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int LOCK_FILTER   = DEF_LOCK_FILTER,
    parameter int RST_HOLD      = DEF_RST_HOLD,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int PLLRST_CYCLES = DEF_PLLRST_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             sw_restart,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             lost_lock,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int LF    = (LOCK_FILTER   < 1) ? 1 : LOCK_FILTER;
    localparam int RH    = (RST_HOLD      < 1) ? 1 : RST_HOLD;
    localparam int LT    = (LOCK_TIMEOUT  < 1) ? 1 : LOCK_TIMEOUT;
    localparam int PR    = (PLLRST_CYCLES < 1) ? 1 : PLLRST_CYCLES;
    localparam int MAX_A = (LF > RH) ? LF : RH;
    localparam int MAX_B = (LT > PR) ? LT : PR;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = clog2(MAX_P) + 1;

    // The counter starts at 0 on entry and counts down; a state of N cycles ends at -(N-1).
    localparam logic [CW-1:0] END_PLLRST  = CW'(1 - PR);
    localparam logic [CW-1:0] END_TIMEOUT = CW'(1 - LT);
    localparam logic [CW-1:0] END_FILTER  = CW'(1 - LF);
    localparam logic [CW-1:0] END_HOLD    = CW'(1 - RH);

    pll_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             ready_q, ready_d;
    logic             lost_lock_q, lost_lock_d;
    logic             locked_s;
    logic             timeout_evt;
    logic             loss_evt;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PLLRST;
            cnt_q         <= '0;
            loss_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            pll_rst_q     <= 1'b1;
            sys_rst_n_q   <= 1'b0;
            ready_q       <= 1'b0;
            lost_lock_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            pll_rst_q     <= pll_rst_d;
            sys_rst_n_q   <= sys_rst_n_d;
            ready_q       <= ready_d;
            lost_lock_q   <= lost_lock_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timeout_evt = 1'b0;
        loss_evt    = 1'b0;
        if (sw_restart) begin
            state_d = PLLRST;
        end else begin
            case (state_q)
                PLLRST: begin
                    if (cnt_q == END_PLLRST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = FILTER;
                    end else if (cnt_q == END_TIMEOUT) begin
                        state_d     = PLLRST;
                        timeout_evt = 1'b1;
                    end
                end
                FILTER: begin
                    if (!locked_s)                state_d = WAIT_LOCK;
                    else if (cnt_q == END_FILTER) state_d = HOLD;
                end
                HOLD: begin
                    if (!locked_s)              state_d = WAIT_LOCK;
                    else if (cnt_q == END_HOLD) state_d = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d  = WAIT_LOCK;
                        loss_evt = 1'b1;
                    end
                end
                default: state_d = PLLRST;
            endcase
        end

        // A held restart keeps reloading so PLLRST always lasts its full width after release.
        cnt_d = (sw_restart || (state_d != state_q)) ? '0 : cnt_q - CW'(1);

        timeout_cnt_d = timeout_cnt_q;
        if (timeout_evt && (timeout_cnt_q != '1)) timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
        loss_cnt_d = loss_cnt_q;
        if (loss_evt && (loss_cnt_q != '1)) loss_cnt_d = loss_cnt_q + CNT_W'(1);
    end

    always_comb begin
        pll_rst_d   = (state_d == PLLRST);
        sys_rst_n_d = (state_d == RUN);
        ready_d     = (state_d == RUN);
        lost_lock_d = loss_evt;
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign ready       = ready_q;
    assign lost_lock   = lost_lock_q;
    assign loss_cnt    = loss_cnt_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    localparam int LF  = 8;
    localparam int RH  = 4;
    localparam int LT  = 32;
    localparam int PR  = 3;
    localparam int CW  = 2;
    localparam int REL = 2 + LF + RH;

    localparam int S_PLLRST  = 0;
    localparam int S_SYSRSTN = 1;
    localparam int S_READY   = 2;
    localparam int S_LOST    = 3;
    localparam int S_LOSS    = 4;
    localparam int S_TMO     = 5;

    typedef struct {
        int at;
        int sel;
        int val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          sw_restart = 1'b0;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          ready;
    logic          lost_lock;
    logic [CW-1:0] loss_cnt;
    logic [CW-1:0] timeout_cnt;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    pll_lock_supervisor #(
        .LOCK_FILTER   (LF),
        .RST_HOLD      (RH),
        .LOCK_TIMEOUT  (LT),
        .PLLRST_CYCLES (PR),
        .CNT_W         (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .sw_restart  (sw_restart),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .ready       (ready),
        .lost_lock   (lost_lock),
        .loss_cnt    (loss_cnt),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] sig_val(input int sel);
        case (sel)
            S_PLLRST:  return {31'd0, pll_rst};
            S_SYSRSTN: return {31'd0, sys_rst_n};
            S_READY:   return {31'd0, ready};
            S_LOST:    return {31'd0, lost_lock};
            S_LOSS:    return {30'd0, loss_cnt};
            default:   return {30'd0, timeout_cnt};
        endcase
    endfunction

    function automatic string sig_name(input int sel);
        case (sel)
            S_PLLRST:  return "pll_rst";
            S_SYSRSTN: return "sys_rst_n";
            S_READY:   return "ready";
            S_LOST:    return "lost_lock";
            S_LOSS:    return "loss_cnt";
            default:   return "timeout_cnt";
        endcase
    endfunction

    task automatic expect_at(input int at, input int sel, input int val);
        exp_t e;
        int   idx;
        e.at  = at;
        e.sel = sel;
        e.val = val;
        idx   = sb_q.size();
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at > at) idx = i;
        end
        sb_q.insert(idx, e);
    endtask

    task automatic expect_release(input int at);
        expect_at(at - 1, S_SYSRSTN, 0);
        expect_at(at - 1, S_READY, 0);
        expect_at(at, S_SYSRSTN, 1);
        expect_at(at, S_READY, 1);
        expect_at(at, S_LOST, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.at < cyc) check_val({"late_", sig_name(e.sel)}, cyc, e.at);
            else            check_val(sig_name(e.sel), sig_val(e.sel), e.val);
        end
    end

    // Lock drop in RUN, then relock with an optional one-cycle glitch at position glitch.
    task automatic lose_relock(input int prev_loss, input int new_loss, input int glitch);
        int c;
        int rel;
        c = cyc;
        pll_locked = 1'b0;
        expect_at(c + 2, S_SYSRSTN, 1);
        expect_at(c + 3, S_SYSRSTN, 0);
        expect_at(c + 2, S_LOST, 0);
        expect_at(c + 3, S_LOST, 1);
        expect_at(c + 4, S_LOST, 0);
        expect_at(c + 2, S_LOSS, prev_loss);
        expect_at(c + 3, S_LOSS, new_loss);
        idle(5);
        c = cyc;
        pll_locked = 1'b1;
        rel = (glitch > 0) ? c + REL + 1 + glitch + 1 : c + REL + 1;
        expect_release(rel);
        expect_at(rel, S_LOSS, new_loss);
        if (glitch > 0) begin
            idle(glitch);
            pll_locked = 1'b0;
            idle(1);
            pll_locked = 1'b1;
        end
        wait_until(rel + 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int r;
        int c;

        idle(3);
        check_val("rst_pll_rst", pll_rst, 1);
        check_val("rst_sys_rst_n", sys_rst_n, 0);
        check_val("rst_ready", ready, 0);
        check_val("rst_lost_lock", lost_lock, 0);
        check_val("rst_loss_cnt", loss_cnt, 0);
        check_val("rst_timeout_cnt", timeout_cnt, 0);

        // No lock: pll_rst pulses and timeouts saturate.
        rst_n = 1'b1;
        r = cyc;
        expect_at(r + 1, S_PLLRST, 1);
        expect_at(r + 2, S_PLLRST, 1);
        expect_at(r + 3, S_PLLRST, 0);
        expect_at(r + 34, S_PLLRST, 0);
        expect_at(r + 35, S_PLLRST, 1);
        expect_at(r + 37, S_PLLRST, 1);
        expect_at(r + 38, S_PLLRST, 0);
        expect_at(r + 34, S_TMO, 0);
        expect_at(r + 35, S_TMO, 1);
        expect_at(r + 69, S_TMO, 1);
        expect_at(r + 70, S_TMO, 2);
        expect_at(r + 105, S_TMO, 3);
        expect_at(r + 140, S_TMO, 3);
        expect_at(r + 140, S_SYSRSTN, 0);
        expect_at(r + 143, S_PLLRST, 0);
        idle(145);

        // Clean lock.
        c = cyc;
        pll_locked = 1'b1;
        expect_release(c + REL + 1);
        wait_until(c + REL + 4);

        // Loss, then relock with a glitch three cycles into the lock.
        lose_relock(0, 1, 3);

        // One-cycle software restart from RUN.
        c = cyc;
        sw_restart = 1'b1;
        expect_at(c + 1, S_PLLRST, 1);
        expect_at(c + 1, S_SYSRSTN, 0);
        expect_at(c + 1, S_READY, 0);
        expect_at(c + 1, S_LOST, 0);
        expect_at(c + 3, S_PLLRST, 1);
        expect_at(c + 4, S_PLLRST, 0);
        expect_at(c + 4, S_LOSS, 1);
        expect_at(c + 4, S_TMO, 3);
        expect_release(c + 17);
        idle(1);
        sw_restart = 1'b0;
        wait_until(c + 20);

        // Restart coinciding with the lock drop reaching the FSM.
        c = cyc;
        pll_locked = 1'b0;
        expect_at(c + 2, S_SYSRSTN, 1);
        expect_at(c + 3, S_SYSRSTN, 0);
        expect_at(c + 3, S_PLLRST, 1);
        expect_at(c + 3, S_LOST, 0);
        expect_at(c + 4, S_LOST, 0);
        expect_at(c + 4, S_LOSS, 1);
        idle(2);
        sw_restart = 1'b1;
        idle(1);
        sw_restart = 1'b0;
        wait_until(c + 10);
        c = cyc;
        pll_locked = 1'b1;
        expect_release(c + REL + 1);
        wait_until(c + REL + 4);

        lose_relock(1, 2, 0);
        lose_relock(2, 3, 0);
        lose_relock(3, 3, 0);

        // Held restart, then async reset in the middle of HOLD.
        c = cyc;
        sw_restart = 1'b1;
        for (int i = 1; i <= 12; i++) expect_at(c + i, S_PLLRST, 1);
        expect_at(c + 10, S_SYSRSTN, 0);
        expect_at(c + 13, S_PLLRST, 0);
        expect_at(c + 23, S_SYSRSTN, 0);
        expect_at(c + 23, S_LOSS, 3);
        idle(10);
        sw_restart = 1'b0;
        wait_until(c + 24);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_pll_rst", pll_rst, 1);
        check_val("async_sys_rst_n", sys_rst_n, 0);
        check_val("async_ready", ready, 0);
        check_val("async_lost_lock", lost_lock, 0);
        check_val("async_loss_cnt", loss_cnt, 0);
        check_val("async_timeout_cnt", timeout_cnt, 0);
        idle(2);
        check_val("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
